// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: DEPTH stages carrying control, operands and register fields,
// with per-stage valid, FLUSH-over-STALL squash and saturating stall/flush event counters.
module id_ex_stage_reg #(
   parameter int unsigned CTRL_W   = 24,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 4,
   parameter int unsigned RADDR_W  = 5,
   parameter int unsigned DEPTH    = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   input  logic                         STALL,
   input  logic                         FLUSH,
   input  logic                         VALID_IN,
   input  logic [CTRL_W-1:0]            CTRL_IN,
   input  logic                         REG_WRITE_IN,
   input  logic [NUM_DATA*DATA_W-1:0]   DATA_IN,
   input  logic [RADDR_W-1:0]           RD_IN,
   input  logic [RADDR_W-1:0]           RS1_IN,
   input  logic [RADDR_W-1:0]           RS2_IN,
   input  logic                         CNT_CLR,
   output logic                         VALID_OUT,
   output logic [CTRL_W-1:0]            CTRL_OUT,
   output logic                         REG_WRITE_OUT,
   output logic [NUM_DATA*DATA_W-1:0]   DATA_OUT,
   output logic [RADDR_W-1:0]           RD_OUT,
   output logic [RADDR_W-1:0]           RS1_OUT,
   output logic [RADDR_W-1:0]           RS2_OUT,
   output logic [CNT_W-1:0]             STALL_CNT,
   output logic [CNT_W-1:0]             FLUSH_CNT
);

   localparam int unsigned OPS_W = NUM_DATA * DATA_W;

   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("id_ex_stage_reg: DEPTH must be in 1..4");
   end

   typedef struct packed {
      logic               valid;
      logic [CTRL_W-1:0]  ctrl;
      logic               reg_write;
      logic [OPS_W-1:0]   data;
      logic [RADDR_W-1:0] rd;
      logic [RADDR_W-1:0] rs1;
      logic [RADDR_W-1:0] rs2;
   } stage_t;

   stage_t             stage_q [DEPTH];
   stage_t             stage_d [DEPTH];
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   // Bubbles carry zero control so they can never write memory or the register file.
   always_comb begin
      stage_d = stage_q;
      if (FLUSH) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            stage_d[k].valid     = 1'b0;
            stage_d[k].ctrl      = '0;
            stage_d[k].reg_write = 1'b0;
         end
      end else if (!STALL) begin
         stage_d[0].valid     = VALID_IN;
         stage_d[0].ctrl      = VALID_IN ? CTRL_IN : '0;
         stage_d[0].reg_write = VALID_IN & REG_WRITE_IN;
         stage_d[0].data      = DATA_IN;
         stage_d[0].rd        = RD_IN;
         stage_d[0].rs1       = RS1_IN;
         stage_d[0].rs2       = RS2_IN;
         for (int k = 1; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
         end
      end
   end

   // Saturating event counters; clear beats a same-cycle increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (CNT_CLR) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (STALL && !FLUSH && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (FLUSH && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            stage_q[k] <= '0;
         end
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stage_q     <= stage_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign VALID_OUT     = stage_q[DEPTH-1].valid;
   assign CTRL_OUT      = stage_q[DEPTH-1].ctrl;
   assign REG_WRITE_OUT = stage_q[DEPTH-1].reg_write;
   assign DATA_OUT      = stage_q[DEPTH-1].data;
   assign RD_OUT        = stage_q[DEPTH-1].rd;
   assign RS1_OUT       = stage_q[DEPTH-1].rs1;
   assign RS2_OUT       = stage_q[DEPTH-1].rs2;
   assign STALL_CNT     = stall_cnt_q;
   assign FLUSH_CNT     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a DEPTH=1 and a DEPTH=3/CNT_W=4 instance share one random
// stimulus stream and are checked every cycle against a queue-style model plus literal pins.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

   localparam int unsigned OPS_W = 128;

   typedef struct packed {
      logic             v;
      logic [23:0]      c;
      logic             w;
      logic [OPS_W-1:0] d;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
   } ent_t;

   logic CLK = 1'b0;
   logic RESET_N, STALL, FLUSH, VALID_IN, REG_WRITE_IN, CNT_CLR;
   logic [23:0]      CTRL_IN;
   logic [OPS_W-1:0] DATA_IN;
   logic [4:0]       RD_IN, RS1_IN, RS2_IN;

   logic             vo  [2];
   logic [23:0]      co  [2];
   logic             wo  [2];
   logic [OPS_W-1:0] dout[2];
   logic [4:0]       rdo [2];
   logic [4:0]       rs1o[2];
   logic [4:0]       rs2o[2];
   logic [15:0]      sc1, fc1;
   logic [3:0]       sc3, fc3;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   id_ex_stage_reg #(.CTRL_W(24), .DATA_W(32), .NUM_DATA(4), .RADDR_W(5), .DEPTH(1), .CNT_W(16)) u_d1 (
      .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .FLUSH(FLUSH), .VALID_IN(VALID_IN),
      .CTRL_IN(CTRL_IN), .REG_WRITE_IN(REG_WRITE_IN), .DATA_IN(DATA_IN), .RD_IN(RD_IN),
      .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .CNT_CLR(CNT_CLR),
      .VALID_OUT(vo[0]), .CTRL_OUT(co[0]), .REG_WRITE_OUT(wo[0]), .DATA_OUT(dout[0]),
      .RD_OUT(rdo[0]), .RS1_OUT(rs1o[0]), .RS2_OUT(rs2o[0]), .STALL_CNT(sc1), .FLUSH_CNT(fc1));

   id_ex_stage_reg #(.CTRL_W(24), .DATA_W(32), .NUM_DATA(4), .RADDR_W(5), .DEPTH(3), .CNT_W(4)) u_d3 (
      .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .FLUSH(FLUSH), .VALID_IN(VALID_IN),
      .CTRL_IN(CTRL_IN), .REG_WRITE_IN(REG_WRITE_IN), .DATA_IN(DATA_IN), .RD_IN(RD_IN),
      .RS1_IN(RS1_IN), .RS2_IN(RS2_IN), .CNT_CLR(CNT_CLR),
      .VALID_OUT(vo[1]), .CTRL_OUT(co[1]), .REG_WRITE_OUT(wo[1]), .DATA_OUT(dout[1]),
      .RD_OUT(rdo[1]), .RS1_OUT(rs1o[1]), .RS2_OUT(rs2o[1]), .STALL_CNT(sc3), .FLUSH_CNT(fc3));

   task automatic chk(input string name, input logic [OPS_W-1:0] act, input logic [OPS_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: each instance is a list of DEPTH slots, newest first.
   ent_t m [2][4];
   int   msc [2];
   int   mfc [2];
   int   dep [2] = '{1, 3};
   int   cmax[2] = '{65535, 15};

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) m[i][k] <= '0;
            msc[i] <= 0;
            mfc[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (FLUSH) begin
               for (int k = 0; k < dep[i]; k++) begin
                  m[i][k].v <= 1'b0;
                  m[i][k].c <= '0;
                  m[i][k].w <= 1'b0;
               end
            end else if (!STALL) begin
               for (int k = 1; k < dep[i]; k++) m[i][k] <= m[i][k-1];
               m[i][0] <= '{v: VALID_IN, c: (VALID_IN ? CTRL_IN : 24'h0), w: VALID_IN & REG_WRITE_IN,
                            d: DATA_IN, rd: RD_IN, rs1: RS1_IN, rs2: RS2_IN};
            end
            if (CNT_CLR) begin
               msc[i] <= 0;
               mfc[i] <= 0;
            end else begin
               if (STALL && !FLUSH) msc[i] <= (msc[i] < cmax[i]) ? msc[i] + 1 : cmax[i];
               if (FLUSH)           mfc[i] <= (mfc[i] < cmax[i]) ? mfc[i] + 1 : cmax[i];
            end
         end
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge CLK) begin
      if (RESET_N === 1'b1) begin
         for (int i = 0; i < 2; i++) begin
            ent_t e;
            e = m[i][dep[i]-1];
            chk($sformatf("valid[%0d]", i), OPS_W'(vo[i]),   OPS_W'(e.v));
            chk($sformatf("ctrl[%0d]", i),  OPS_W'(co[i]),   OPS_W'(e.c));
            chk($sformatf("we[%0d]", i),    OPS_W'(wo[i]),   OPS_W'(e.w));
            chk($sformatf("data[%0d]", i),  dout[i],         e.d);
            chk($sformatf("rd[%0d]", i),    OPS_W'(rdo[i]),  OPS_W'(e.rd));
            chk($sformatf("rs1[%0d]", i),   OPS_W'(rs1o[i]), OPS_W'(e.rs1));
            chk($sformatf("rs2[%0d]", i),   OPS_W'(rs2o[i]), OPS_W'(e.rs2));
            if (!vo[i]) chk($sformatf("bubble_inv[%0d]", i), OPS_W'({co[i], wo[i]}), '0);
         end
         chk("stall_cnt1", OPS_W'(sc1), OPS_W'(msc[0]));
         chk("flush_cnt1", OPS_W'(fc1), OPS_W'(mfc[0]));
         chk("stall_cnt3", OPS_W'(sc3), OPS_W'(msc[1]));
         chk("flush_cnt3", OPS_W'(fc3), OPS_W'(mfc[1]));
      end
   end

   // Drive one cycle of inputs at a falling edge, return at the next falling edge.
   task automatic drv(input logic v, input logic [23:0] c, input logic we,
                      input logic st, input logic fl, input logic clr);
      VALID_IN = v; CTRL_IN = c; REG_WRITE_IN = we;
      STALL = st; FLUSH = fl; CNT_CLR = clr;
      DATA_IN = {$urandom, $urandom, $urandom, $urandom};
      RD_IN = 5'($urandom); RS1_IN = 5'($urandom); RS2_IN = 5'($urandom);
      @(negedge CLK);
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drv(($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      STALL = 0; FLUSH = 0; VALID_IN = 0; CTRL_IN = '0; REG_WRITE_IN = 0;
      DATA_IN = '0; RD_IN = '0; RS1_IN = '0; RS2_IN = '0; CNT_CLR = 0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      chk("rst_valid1", OPS_W'(vo[0]), '0);
      chk("rst_cnt1",   OPS_W'({sc1, fc1}), '0);

      // Pass-through on DEPTH=1
      VALID_IN = 1; CTRL_IN = 24'hA5A5A5; REG_WRITE_IN = 1; RD_IN = 5'd7;
      RS1_IN = 5'd3; RS2_IN = 5'd4; STALL = 0; FLUSH = 0; CNT_CLR = 1;
      DATA_IN = {32'hDEAD_BEEF, 32'h0000_0040, 32'hCAFE_F00D, 32'h1234_5678};
      @(negedge CLK);
      chk("pt_valid", OPS_W'(vo[0]), OPS_W'(1));
      chk("pt_ctrl",  OPS_W'(co[0]), OPS_W'(24'hA5A5A5));
      chk("pt_op0",   OPS_W'(dout[0][31:0]), OPS_W'(32'h1234_5678));
      chk("pt_rd",    OPS_W'(rdo[0]), OPS_W'(7));
      chk("pt_we",    OPS_W'(wo[0]), OPS_W'(1));

      // Stall hold for 3 cycles with different inputs
      for (int i = 0; i < 3; i++) begin
         drv(1, 24'h111111 * 24'(i + 1), 0, 1, 0, 0);
         chk("stall_hold_ctrl", OPS_W'(co[0]), OPS_W'(24'hA5A5A5));
         chk("stall_hold_rd",   OPS_W'(rdo[0]), OPS_W'(7));
      end
      chk("stall_cnt_3", OPS_W'(sc1), OPS_W'(3));
      drv(1, 24'h5A5A5A, 1, 0, 0, 0);
      chk("stall_release", OPS_W'(co[0]), OPS_W'(24'h5A5A5A));

      // Flush together with stall while a valid instruction is presented
      drv(1, 24'h5A5A5A, 1, 1, 1, 0);
      chk("flush_valid", OPS_W'(vo[0]), '0);
      chk("flush_ctrl",  OPS_W'(co[0]), '0);
      chk("flush_we",    OPS_W'(wo[0]), '0);
      chk("flush_cnt_1", OPS_W'(fc1), OPS_W'(1));
      chk("flush_sc_kept", OPS_W'(sc1), OPS_W'(3));

      // DEPTH=3: A, bubble, B emerge after edges 3/4/5
      drv(1, 24'h0000AA, 1, 0, 0, 0);
      drv(0, 24'hFFFFFF, 1, 0, 0, 0);
      drv(1, 24'h0000BB, 1, 0, 0, 0);
      chk("d3_A_ctrl", OPS_W'(co[1]), OPS_W'(24'h0000AA));
      chk("d3_A_valid", OPS_W'(vo[1]), OPS_W'(1));
      drv(0, 24'h0, 0, 0, 0, 0);
      chk("d3_bub_ctrl", OPS_W'(co[1]), '0);
      chk("d3_bub_valid", OPS_W'(vo[1]), '0);
      drv(0, 24'h0, 0, 0, 0, 0);
      chk("d3_B_ctrl", OPS_W'(co[1]), OPS_W'(24'h0000BB));

      // Same stream with one stall cycle after A: everything slips one edge
      drv(1, 24'h0000AA, 1, 0, 0, 0);
      drv(1, 24'h777777, 1, 1, 0, 0);
      drv(0, 24'hFFFFFF, 1, 0, 0, 0);
      chk("d3s_not_yet", OPS_W'(co[1]), OPS_W'(24'h0));
      drv(1, 24'h0000BB, 1, 0, 0, 0);
      chk("d3s_A_ctrl", OPS_W'(co[1]), OPS_W'(24'h0000AA));
      drv(0, 24'h0, 0, 0, 0, 0);
      chk("d3s_bub_ctrl", OPS_W'(co[1]), '0);
      drv(0, 24'h0, 0, 0, 0, 0);
      chk("d3s_B_ctrl", OPS_W'(co[1]), OPS_W'(24'h0000BB));

      // Counter saturation on the 4-bit instance, then clear beats increment
      drv(0, 24'h0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) drv(1'($urandom), 24'($urandom), 1, 1, 0, 0);
      chk("sat_sc3", OPS_W'(sc3), OPS_W'(15));
      chk("sat_sc1", OPS_W'(sc1), OPS_W'(20));
      drv(1, 24'h0, 1, 1, 0, 1);
      chk("clr_sc3", OPS_W'(sc3), '0);
      chk("clr_sc1", OPS_W'(sc1), '0);

      rand_cycles(400);

      // Asynchronous reset mid-cycle with loaded stages
      drv(1, 24'h123456, 1, 0, 0, 0);
      drv(1, 24'h654321, 1, 1, 0, 0);
      #2 RESET_N = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("arst_ctrl[%0d]", i), OPS_W'({vo[i], co[i], wo[i]}), '0);
         chk($sformatf("arst_data[%0d]", i), dout[i], '0);
         chk($sformatf("arst_addr[%0d]", i), OPS_W'({rdo[i], rs1o[i], rs2o[i]}), '0);
      end
      chk("arst_cnt", OPS_W'({sc1, fc1, sc3, fc3}), '0);
      @(negedge CLK);
      RESET_N = 1'b1;
      rand_cycles(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
